// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control, instruction-memory and IF/ID signals.
// The slave modport is the fetch stage itself; the master modport is the
// surrounding pipeline (hazard unit, ID/EX redirect logic, instruction memory).
interface if_stage_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  modport master (
    output stall, branch_taken, branch_target,
    output jump, jump_target, jr, jr_target,
    input  imem_addr,
    output imem_instr,
    input  ifid_instr, ifid_pc_plus4, ifid_valid, fetch_count
  );

  modport slave (
    input  stall, branch_taken, branch_target,
    input  jump, jump_target, jr, jr_target,
    output imem_addr,
    input  imem_instr,
    output ifid_instr, ifid_pc_plus4, ifid_valid, fetch_count
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection (branch, stall,
// jr, jump, sequential) and the IF/ID pipeline register with a count of
// instructions accepted into IF/ID.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  if_stage_if.slave   bus
);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] ifid_instr_reg, ifid_instr_next;
  logic [31:0] ifid_pc_plus4_reg, ifid_pc_plus4_next;
  logic        ifid_valid_reg, ifid_valid_next;
  logic [31:0] fetch_count_reg, fetch_count_next;

  // Word-aligned redirect targets; the low two bits are never loaded into PC.
  logic [31:0] branch_target_aligned;
  logic [31:0] jump_target_aligned;
  logic [31:0] jr_target_aligned;

  assign branch_target_aligned = {bus.branch_target[31:2], 2'b00};
  assign jump_target_aligned   = {bus.jump_target[31:2], 2'b00};
  assign jr_target_aligned     = {bus.jr_target[31:2], 2'b00};

  // Sequential successor wraps naturally at 2^32.
  assign pc_plus4 = pc_reg + 32'd4;

  // Next-PC and IF/ID selection. A taken branch beats a stall because the
  // stalled ID instruction is on the wrong path; jr/jump are ignored under a
  // stall since the held ID instruction re-asserts them later; jr beats jump.
  always_comb begin
    pc_next            = pc_plus4;
    ifid_instr_next    = bus.imem_instr;
    ifid_pc_plus4_next = pc_plus4;
    ifid_valid_next    = 1'b1;
    fetch_count_next   = fetch_count_reg + 32'd1;

    if (bus.branch_taken) begin
      pc_next            = branch_target_aligned;
      ifid_instr_next    = 32'h00000000;
      ifid_pc_plus4_next = 32'h00000000;
      ifid_valid_next    = 1'b0;
      fetch_count_next   = fetch_count_reg;
    end else if (bus.stall) begin
      pc_next            = pc_reg;
      ifid_instr_next    = ifid_instr_reg;
      ifid_pc_plus4_next = ifid_pc_plus4_reg;
      ifid_valid_next    = ifid_valid_reg;
      fetch_count_next   = fetch_count_reg;
    end else if (bus.jr || bus.jump) begin
      pc_next            = bus.jr ? jr_target_aligned : jump_target_aligned;
      ifid_instr_next    = 32'h00000000;
      ifid_pc_plus4_next = 32'h00000000;
      ifid_valid_next    = 1'b0;
      fetch_count_next   = fetch_count_reg;
    end
  end

  // State registers; reset discards any pending stall or redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg            <= RESET_PC;
      ifid_instr_reg    <= 32'h00000000;
      ifid_pc_plus4_reg <= 32'h00000000;
      ifid_valid_reg    <= 1'b0;
      fetch_count_reg   <= 32'h00000000;
    end else begin
      pc_reg            <= pc_next;
      ifid_instr_reg    <= ifid_instr_next;
      ifid_pc_plus4_reg <= ifid_pc_plus4_next;
      ifid_valid_reg    <= ifid_valid_next;
      fetch_count_reg   <= fetch_count_next;
    end
  end

  assign bus.imem_addr     = pc_reg;
  assign bus.ifid_instr    = ifid_instr_reg;
  assign bus.ifid_pc_plus4 = ifid_pc_plus4_reg;
  assign bus.ifid_valid    = ifid_valid_reg;
  assign bus.fetch_count   = fetch_count_reg;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: each step drives one cycle of inputs and
// queues the hand-computed post-edge outputs; a monitor pops and compares.
module tb_if_stage;

  logic clk;
  logic reset;

  if_stage_if bus ();

  if_stage #(.RESET_PC(32'h00000000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: three fixed words at 0/4/8, otherwise a tag of the address.
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    case (a)
      32'h00000000: instr_at = 32'h00002821;
      32'h00000004: instr_at = 32'h20a40004;
      32'h00000008: instr_at = 32'h8ca50000;
      default:      instr_at = {8'hA0, a[23:0]};
    endcase
  endfunction

  assign bus.imem_instr = instr_at(bus.imem_addr);

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void check32(input string nm, input string fld,
                                  input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, req);
    end
  endfunction

  // Monitor: one expected entry per clock edge, sampled on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check32(e.name, "imem_addr", bus.imem_addr, e.addr);
      check32(e.name, "ifid_instr", bus.ifid_instr, e.instr);
      check32(e.name, "ifid_pc_plus4", bus.ifid_pc_plus4, e.pc4);
      check32(e.name, "ifid_valid", {31'd0, bus.ifid_valid}, {31'd0, e.valid});
      check32(e.name, "fetch_count", bus.fetch_count, e.fc);
      $display("txn %-14s addr=%h instr=%h pc4=%h v=%b fc=%0d",
               e.name, bus.imem_addr, bus.ifid_instr, bus.ifid_pc_plus4,
               bus.ifid_valid, bus.fetch_count);
    end
  end

  task automatic step(input string nm, input logic rst, input logic st,
                      input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt,
                      input logic jrr, input logic [31:0] jrt,
                      input logic [31:0] e_addr, input logic [31:0] e_instr,
                      input logic [31:0] e_pc4, input logic e_v,
                      input logic [31:0] e_fc);
    exp_t e;
    @(negedge clk);
    #1;
    reset             = rst;
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = bt;
    bus.jump          = jp;
    bus.jump_target   = jt;
    bus.jr            = jrr;
    bus.jr_target     = jrt;
    e.name  = nm;
    e.addr  = e_addr;
    e.instr = e_instr;
    e.pc4   = e_pc4;
    e.valid = e_v;
    e.fc    = e_fc;
    exp_q.push_back(e);
  endtask

  initial begin
    reset             = 1'b1;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.jump          = 1'b0;
    bus.jump_target   = 32'h0;
    bus.jr            = 1'b0;
    bus.jr_target     = 32'h0;

    //   name            rst st br bt            jp jt            jr jrt           addr          instr         pc4           v  fc
    step("reset_junk",   1, 1, 1, 32'h00000030, 1, 32'h00000100, 1, 32'h00000200, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0);
    step("reset",        1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h00000000, 32'h00000000, 32'h00000000, 0, 0);
    step("free0",        0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h00000004, 32'h00002821, 32'h00000004, 1, 1);
    step("free1",        0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h00000008, 32'h20a40004, 32'h00000008, 1, 2);
    step("stall1",       0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h00000008, 32'h20a40004, 32'h00000008, 1, 2);
    step("stall2_jump",  0, 1, 0, 32'h0,        1, 32'h00000100, 0, 32'h0,        32'h00000008, 32'h20a40004, 32'h00000008, 1, 2);
    step("resume",       0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000000C, 32'h8ca50000, 32'h0000000C, 1, 3);
    step("jump",         0, 0, 0, 32'h0,        1, 32'h004000B6, 0, 32'h0,        32'h004000B4, 32'h00000000, 32'h00000000, 0, 3);
    step("jump_tgt",     0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h004000B8, 32'hA04000B4, 32'h004000B8, 1, 4);
    step("br_over_stl",  0, 1, 1, 32'h00000033, 0, 32'h0,        0, 32'h0,        32'h00000030, 32'h00000000, 32'h00000000, 0, 4);
    step("br_tgt",       0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h00000034, 32'hA0000030, 32'h00000034, 1, 5);
    step("jr_and_jump",  0, 0, 0, 32'h0,        1, 32'h00000100, 1, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'h00000000, 32'h00000000, 0, 5);
    step("wrap",         0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h00000000, 32'hA0FFFFFC, 32'h00000000, 1, 6);
    step("after_wrap",   0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h00000004, 32'h00002821, 32'h00000004, 1, 7);
    step("stall_jr",     0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h00000200, 32'h00000004, 32'h00002821, 32'h00000004, 1, 7);
    step("rst_stl_jump", 1, 1, 0, 32'h0,        1, 32'h00000100, 0, 32'h0,        32'h00000000, 32'h00000000, 32'h00000000, 0, 0);
    step("post_reset",   0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h00000004, 32'h00002821, 32'h00000004, 1, 1);

    // Drain: allow a bounded number of cycles for the monitor to consume the queue.
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
